// File: rtl/led_matrix_rx_if.sv
// Serial link inputs and decoded/display outputs of the LED-matrix receiver.
// Latency: none (wiring only).
// Backpressure: none; the serial link is push-only.
interface led_matrix_rx_if;
  logic       ser_clk_in;
  logic       ser_valid_in;
  logic       ser_data_in;
  logic [7:0] byte_out;
  logic       byte_valid_out;
  logic [2:0] row_idx_out;
  logic       frame_done_out;
  logic       err_out;
  logic [7:0] row_sel_out;
  logic [7:0] col_out;

  // Transmitter / bench side
  modport master (
    output ser_clk_in, ser_valid_in, ser_data_in,
    input  byte_out, byte_valid_out, row_idx_out, frame_done_out, err_out,
    input  row_sel_out, col_out
  );

  // Receiver side
  modport slave (
    input  ser_clk_in, ser_valid_in, ser_data_in,
    output byte_out, byte_valid_out, row_idx_out, frame_done_out, err_out,
    output row_sel_out, col_out
  );
endinterface

// File: rtl/led_matrix_rx.sv
// LED-matrix serial receiver: assembles LSB-first bytes into an 8x8 frame and scans it out.
// Latency: byte_valid_out one cycle after the 8th sample, which is SYNC_STAGES+1 cycles after ser_clk falls.
// Backpressure: none; samples landing in the STORE cycle are dropped. Option LED_MATRIX_RX_DOUBLE_BUFFER_EN.
module led_matrix_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int SCAN_DIV    = 50000,
  parameter int TIMEOUT_CYC = 150000000
) (
  input logic           clk_in,
  input logic           rst_n_in,
  led_matrix_rx_if.slave lnk
);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RECV, STORE} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, vld_sync, dat_sync;
  logic                   clk_prev;
  logic                   sample, ser_vld, ser_dat;

  state_t      state;
  logic [7:0]  shift, shift_nxt;
  logic [3:0]  bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]  byte_r;
  logic        byte_vld_r, frame_done_r, err_r;
  logic [2:0]  row_idx;
  logic [7:0]  display_buf [8];
`ifdef LED_MATRIX_RX_DOUBLE_BUFFER_EN
  logic [7:0]  back_buf [8];
`endif

  logic [SW-1:0] scan_cnt;
  logic [2:0]    scan_row, scan_nxt;
  logic [7:0]    row_sel_r, col_r;

  assign ser_vld  = vld_sync[SYNC_STAGES-1];
  assign ser_dat  = dat_sync[SYNC_STAGES-1];
  // Mid-bit sample: falling edge of the synchronized serial clock
  assign sample   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign scan_nxt = scan_row + 3'd1;

  // Bring the asynchronous serial lines into clk_in and keep one stage of clock history
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      clk_sync <= '0;
      vld_sync <= '0;
      dat_sync <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], lnk.ser_clk_in};
      vld_sync <= {vld_sync[SYNC_STAGES-2:0], lnk.ser_valid_in};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], lnk.ser_data_in};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  // Shift register with the current sample inserted at bit_cnt
  always_comb begin
    shift_nxt = shift;
    shift_nxt[bit_cnt[2:0]] = ser_dat;
  end

  // Receive FSM; the completed byte, buffer write and row advance all take effect
  // on the edge entering STORE so they are visible for the whole STORE cycle
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      shift        <= '0;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      byte_r       <= '0;
      byte_vld_r   <= 1'b0;
      frame_done_r <= 1'b0;
      err_r        <= 1'b0;
      row_idx      <= '0;
      for (int r = 0; r < 8; r++) begin
        display_buf[r] <= '0;
`ifdef LED_MATRIX_RX_DOUBLE_BUFFER_EN
        back_buf[r]    <= '0;
`endif
      end
    end else begin
      byte_vld_r   <= 1'b0;
      frame_done_r <= 1'b0;
      err_r        <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (sample && ser_vld) begin
            shift   <= {7'd0, ser_dat};
            bit_cnt <= 4'd1;
            state   <= RECV;
          end
        end
        RECV: begin
          if (sample) begin
            to_cnt <= '0;
            if (ser_vld) begin
              shift   <= shift_nxt;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                state        <= STORE;
                byte_r       <= shift_nxt;
                byte_vld_r   <= 1'b1;
                frame_done_r <= (row_idx == 3'd7);
                row_idx      <= row_idx + 3'd1;
`ifdef LED_MATRIX_RX_DOUBLE_BUFFER_EN
                back_buf[row_idx] <= shift_nxt;
                // Completing row 7 publishes the whole frame at once
                if (row_idx == 3'd7) begin
                  for (int r = 0; r < 7; r++) display_buf[r] <= back_buf[r];
                  display_buf[7] <= shift_nxt;
                end
`else
                display_buf[row_idx] <= shift_nxt;
`endif
              end
            end else begin
              err_r   <= 1'b1;
              shift   <= '0;
              bit_cnt <= '0;
              state   <= IDLE;
            end
          end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            err_r   <= 1'b1;
            shift   <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        STORE: begin
          bit_cnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row scan: dwell SCAN_DIV cycles per row; col_out refreshes every cycle so a
  // write to the displayed row appears before the next row change
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      scan_cnt  <= '0;
      scan_row  <= '0;
      row_sel_r <= 8'b0000_0001;
      col_r     <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      scan_row  <= scan_nxt;
      row_sel_r <= 8'd1 << scan_nxt;
      col_r     <= display_buf[scan_nxt];
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
      col_r     <= display_buf[scan_row];
    end
  end

  assign lnk.byte_out       = byte_r;
  assign lnk.byte_valid_out = byte_vld_r;
  assign lnk.row_idx_out    = row_idx;
  assign lnk.frame_done_out = frame_done_r;
  assign lnk.err_out        = err_r;
  assign lnk.row_sel_out    = row_sel_r;
  assign lnk.col_out        = col_r;
endmodule

// File: tb/tb_led_matrix_rx.sv
// Directed bench for led_matrix_rx with a byte scoreboard and display model.
// Latency: sample-to-error timing checked against the timeout window.
// Backpressure: n/a; the bench is the transmitter.
module tb_led_matrix_rx;
  logic clk = 1'b0;
  logic rst_n;

  led_matrix_rx_if lnk();

  led_matrix_rx #(.SYNC_STAGES(2), .SCAN_DIV(4), .TIMEOUT_CYC(64)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .lnk     (lnk)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_bv     = 0;
  int n_fd     = 0;
  int n_err    = 0;

  logic [7:0] exp_q [$];
  logic [7:0] back_model [8];
  logic [7:0] disp_model [8];
  logic [2:0] row_model;
  logic [7:0] mon_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every byte_valid pulse pops the next expected byte
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (lnk.byte_valid_out === 1'b1) begin
        n_bv++;
        chk("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          chk("byte_out", {24'd0, lnk.byte_out}, {24'd0, mon_exp});
        end
      end
      if (lnk.frame_done_out === 1'b1) n_fd++;
      if (lnk.err_out === 1'b1) n_err++;
    end
  end

  function automatic int row_of(input logic [7:0] s);
    for (int i = 0; i < 8; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 8; r++) begin
      back_model[r] = 8'd0;
      disp_model[r] = 8'd0;
    end
    row_model = 3'd0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_byte_out"},   {24'd0, lnk.byte_out},    32'd0);
    chk({tag, "_byte_valid"}, {31'd0, lnk.byte_valid_out}, 32'd0);
    chk({tag, "_row_idx"},    {29'd0, lnk.row_idx_out}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, lnk.frame_done_out}, 32'd0);
    chk({tag, "_err"},        {31'd0, lnk.err_out},     32'd0);
    chk({tag, "_row_sel"},    {24'd0, lnk.row_sel_out}, 32'h01);
    chk({tag, "_col"},        {24'd0, lnk.col_out},     32'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    lnk.ser_clk_in = 1'b0; lnk.ser_valid_in = 1'b0; lnk.ser_data_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    clear_model();
  endtask

  // One serial bit: 8 cycles high, then the mid-bit falling edge and 8 cycles low
  task automatic send_bit(input logic v, input logic d);
    lnk.ser_valid_in = v;
    lnk.ser_data_in  = d;
    lnk.ser_clk_in   = 1'b1;
    repeat (8) @(negedge clk);
    lnk.ser_clk_in   = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back(b);
    back_model[row_model] = b;
`ifdef LED_MATRIX_RX_DOUBLE_BUFFER_EN
    if (row_model == 3'd7) disp_model = back_model;
`else
    disp_model[row_model] = b;
`endif
    row_model = row_model + 3'd1;
    for (int i = 0; i < 8; i++) send_bit(1'b1, b[i]);
    lnk.ser_valid_in = 1'b0;
  endtask

  // Watch 32 cycles of scanning: one-hot walk in order, every row seen, columns match model
  task automatic check_scan(input string tag);
    logic [7:0] prev, seen;
    repeat (5) @(negedge clk);
    prev = lnk.row_sel_out;
    seen = 8'd0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      chk({tag, "_onehot"}, {31'd0, $onehot(lnk.row_sel_out)}, 32'd1);
      if (lnk.row_sel_out != prev)
        chk({tag, "_row_step"}, {24'd0, lnk.row_sel_out}, {24'd0, prev[6:0], prev[7]});
      chk({tag, "_col"}, {24'd0, lnk.col_out}, {24'd0, disp_model[row_of(lnk.row_sel_out)]});
      seen = seen | lnk.row_sel_out;
      prev = lnk.row_sel_out;
    end
    chk({tag, "_rows_visited"}, {24'd0, seen}, 32'hFF);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bv0, fd0, e0, k;
    logic [2:0] ri;
    rst_n = 1'b0;
    lnk.ser_clk_in = 1'b0; lnk.ser_valid_in = 1'b0; lnk.ser_data_in = 1'b0;
    clear_model();
    reset_dut();

    // Single byte 0x2B into row 0
    bv0 = n_bv; e0 = n_err;
    send_byte(8'b0010_1011);
    chk("b2b_pulses", n_bv - bv0, 1);
    chk("b2b_byte_out", {24'd0, lnk.byte_out}, 32'h2B);
    chk("b2b_row_idx", {29'd0, lnk.row_idx_out}, 32'd1);
    chk("b2b_no_err", n_err - e0, 0);

    // Full frame 01..80 from row 0; display after 7 rows, then after the 8th
    reset_dut();
    bv0 = n_bv; fd0 = n_fd;
    for (int r = 0; r < 7; r++) send_byte(8'd1 << r);
    chk("frame_no_done_yet", n_fd - fd0, 0);
    check_scan("scan7");
    send_byte(8'h80);
    chk("frame_done_pulses", n_fd - fd0, 1);
    chk("frame_bytes", n_bv - bv0, 8);
    chk("frame_row_wrap", {29'd0, lnk.row_idx_out}, 32'd0);
    check_scan("scan8");

    // Valid dropped after 3 bits aborts the byte
    bv0 = n_bv; e0 = n_err; ri = lnk.row_idx_out;
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    chk("abort_err", n_err - e0, 1);
    chk("abort_no_byte", n_bv - bv0, 0);
    chk("abort_row_idx", {29'd0, lnk.row_idx_out}, {29'd0, ri});
    send_byte(8'hA5);
    chk("after_abort_byte", n_bv - bv0, 1);
    chk("after_abort_row", {29'd0, lnk.row_idx_out}, {29'd0, ri + 3'd1});
    check_scan("scan_abort");

    // Serial clock stops after 5 bits: error 64 cycles after the last sample,
    // i.e. 3 (sync + edge detect) + 64 clk_in edges after the falling edge
    bv0 = n_bv; e0 = n_err;
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
    lnk.ser_valid_in = 1'b1; lnk.ser_data_in = 1'b1; lnk.ser_clk_in = 1'b1;
    repeat (8) @(negedge clk);
    lnk.ser_clk_in = 1'b0;
    k = 0;
    while (lnk.err_out !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_latency", k, 67);
    repeat (4) @(negedge clk);
    lnk.ser_valid_in = 1'b0;
    chk("timeout_err_once", n_err - e0, 1);
    chk("timeout_no_byte", n_bv - bv0, 0);
    send_byte(8'h5A);
    chk("after_timeout_byte", n_bv - bv0, 1);

    // Asynchronous reset in the middle of bit 4
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
    lnk.ser_valid_in = 1'b1; lnk.ser_data_in = 1'b1; lnk.ser_clk_in = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    lnk.ser_clk_in = 1'b0;
    lnk.ser_valid_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    bv0 = n_bv;
    send_byte(8'h3C);
    chk("post_rst_byte", n_bv - bv0, 1);
    chk("post_rst_row_idx", {29'd0, lnk.row_idx_out}, 32'd1);
    check_scan("scan_rst");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/led_matrix_rx.md
Name: led_matrix_rx

Overview:
- Receiving end of the LED-matrix serial link. It takes the slow serial clock, the valid strobe and the data line from the matrix transmitter.
- Assembles 8-bit rows, LSB first, into an 8x8 frame buffer.
- Continuously multiplexes the frame onto row/column drive lines.
- Runs on the fast board clock; all serial inputs are asynchronous to it.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on ser_clk_in, ser_valid_in and ser_data_in (minimum 2).
- SCAN_DIV, 50000: clk_in cycles each matrix row stays selected.
- TIMEOUT_CYC, 150000000: clk_in cycles without a sample edge in RECV before the partial byte is aborted.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset.
- ser_clk_in  input  1  serial bit clock from the transmitter.
- ser_valid_in  input  1  transmitter strobe; high while a bit is being sent.
- ser_data_in  input  1  serial data bit.
- byte_out  output  8  last completed byte.
- byte_valid_out  output  1  one-cycle pulse when byte_out updates.
- row_idx_out  output  3  frame row the next byte will be written to.
- frame_done_out  output  1  one-cycle pulse when row 7 is written.
- err_out  output  1  one-cycle pulse on an aborted byte.
- row_sel_out  output  8  one-hot row drive, active high.
- col_out  output  8  column data for the selected row, bit i = column i.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_n_in is asynchronous and active-low.
- Reset values, including reset asserted mid-byte:
  - byte_out=0, byte_valid_out=0, frame_done_out=0, err_out=0, row_idx_out=0.
  - row_sel_out=8'b00000001, col_out=0.
  - All frame buffers cleared, FSM to IDLE, any partial byte discarded.
- Synchronization: all three serial inputs pass through SYNC_STAGES flops.
- Sample event: a falling edge of synchronized ser_clk (previous=1, current=0), one clk_in cycle wide. The transmitter updates on the rising edge, so the falling edge is mid-bit.
- Sample latency: SYNC_STAGES+1 clk_in cycles after the ser_clk_in falling edge.
- FSM states IDLE, RECV, STORE:
  - IDLE: sample with valid=1 -> shift[0]=data, bit_cnt=1, go to RECV. Sample with valid=0 is ignored.
  - RECV: sample with valid=1 -> shift[bit_cnt]=data, bit_cnt+1. When bit_cnt reaches 8, go to STORE.
  - RECV: sample with valid=0 -> err_out pulse, discard the partial byte, go to IDLE.
  - RECV: timeout counter reaches TIMEOUT_CYC-1 with no sample -> err_out pulse, go to IDLE. The counter clears on every sample and is idle outside RECV.
  - STORE: lasts exactly one cycle, then returns to IDLE. It performs the following:
    - byte_out<=shift and byte_valid_out=1 for that one cycle.
    - Write shift into buffer row row_idx.
    - row_idx increments and wraps 7->0.
    - frame_done_out pulses if row_idx was 7.
  - A sample event that lands in the STORE cycle is dropped. This cannot occur while the serial period exceeds 2 clk_in cycles.
- byte_valid_out latency: asserts exactly 1 cycle after the 8th sample event.
- Bit order: first received bit -> bit 0.
- Scan counter:
  - Counts 0..SCAN_DIV-1. On wrap, scan_row advances and wraps 7->0.
  - row_sel_out = 1<<scan_row. col_out = display_buf[scan_row], registered and updated together with row_sel_out.
  - A buffer write to the displayed row shows on col_out no later than the next row change.
- Counter widths: $clog2 of their limits, no overflow beyond the limit.

Optional Feature:
- Macro LED_MATRIX_RX_DOUBLE_BUFFER_EN.
- Defined:
  - Bytes are written to a back buffer.
  - On the STORE cycle that writes row 7, the back buffer is copied into the display buffer in the same edge. The display changes only on complete frames.
  - An aborted byte never affects the display.
  - Back-buffer rows from a partial frame persist until overwritten.
- Undefined: there is a single buffer and rows display as soon as they are written.

Test Plan (sim params SCAN_DIV=4, TIMEOUT_CYC=64, ser_clk period 16 clk_in):
- Reset, then send byte 8'b00101011 LSB first with valid high -> byte_valid_out pulses once, byte_out=8'h2B, row_idx_out=1, err_out stays 0.
- Send 8 bytes 8'h01,8'h02,...,8'h80 -> frame_done_out pulses once after the 8th, row_idx_out wraps to 0. Over 32 clocks, row_sel_out walks 01->02->...->80, with col_out equal to 1<<row on each row.
- Send 3 bits, then drop valid at the next sample -> err_out pulses once, no byte_valid_out, row_idx_out unchanged. The next full byte 8'hA5 is received correctly.
- Send 5 bits, then stop ser_clk -> err_out pulses 64 cycles after the last sample, FSM returns to IDLE.
- Assert rst_n_in mid-byte (bit 4) -> all outputs take reset values asynchronously. The following byte 8'h3C lands in row 0.
- With LED_MATRIX_RX_DOUBLE_BUFFER_EN: after 7 rows, col_out shows all zero. After row 8, all 8 rows appear simultaneously on the display.
